muldiv_unit: RTL and testbench

- Iterative 32-bit multiply/divide unit for the MIPS core. Executes MULT, MULTU, DIV and DIVU into architectural HI/LO registers.
- Sits beside the single-cycle ALU in the execute stage. The decode/hazard logic is the initiator: it issues an operation with start and stalls reads of HI/LO while busy is high.
- Also services MTHI/MTLO writes and provides HI/LO for MFHI/MFLO.

---
 rtl/muldiv_if.sv | 20 ++
 rtl/muldiv_unit.sv | 138 +++++++++++++
 tb/tb_muldiv_unit.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Request/response bundle between decode/hazard logic and the multiply/divide unit.
interface muldiv_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        dz;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, A, B, hi_we, lo_we, wdata,
                  input  busy, done, dz, hi, lo);
  modport slave  (input  start, op, A, B, hi_we, lo_we, wdata,
                  output busy, done, dz, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU into HI/LO, plus MTHI/MTLO service.
// MULDIV_DIVZ_EN: divide by zero short-circuits to DONE with dz=1 and HI/LO untouched.
module muldiv_unit #(
  parameter int ITER = 32
) (
  input logic      CLK,
  input logic      nRST,
  muldiv_if.slave  bus
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_ITER = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]  r_state;
  logic [1:0]  r_op;
  logic [31:0] r_a, r_b, r_hi, r_lo;
  logic [31:0] r_ph, r_pl, r_mc;
  logic [5:0]  r_cnt;
  logic        r_neg_p, r_neg_a;

  logic        w_idle, w_accept, w_divz, w_div, w_signed, w_ge, w_bz;
  logic [32:0] w_msum, w_rsh;
  logic [31:0] w_diff, w_mag_a, w_mag_b, w_q, w_r;
  logic [63:0] w_prod, w_prod_s;

  // DONE behaves as idle so a new op can issue with no gap
  assign w_idle   = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_accept = w_idle && bus.start;
`ifdef MULDIV_DIVZ_EN
  assign w_divz   = w_accept && bus.op[1] && (bus.B == 32'd0);
`else
  assign w_divz   = 1'b0;
`endif

  assign w_div    = r_op[1];
  assign w_signed = ~r_op[0];
  assign w_bz     = (r_b == 32'd0);
  assign w_mag_a  = (w_signed && r_a[31]) ? -r_a : r_a;
  assign w_mag_b  = (w_signed && r_b[31]) ? -r_b : r_b;

  // shift-add step: r_ph:r_pl holds partial product with multiplier in the low half
  assign w_msum   = {1'b0, r_ph} + (r_pl[0] ? {1'b0, r_mc} : 33'd0);
  // restoring step: r_ph is partial remainder, r_pl shifts dividend out / quotient in
  assign w_rsh    = {r_ph, r_pl[31]};
  assign w_ge     = (w_rsh >= {1'b0, r_mc});
  assign w_diff   = w_rsh[31:0] - r_mc;

  assign w_prod   = {r_ph, r_pl};
  assign w_prod_s = r_neg_p ? -w_prod : w_prod;
  assign w_q      = r_neg_p ? -r_pl : r_pl;
  assign w_r      = r_neg_a ? -r_ph : r_ph;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= S_IDLE;
      r_op    <= 2'd0;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_ph    <= '0;
      r_pl    <= '0;
      r_mc    <= '0;
      r_cnt   <= '0;
      r_neg_p <= 1'b0;
      r_neg_a <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_op    <= bus.op;
            r_a     <= bus.A;
            r_b     <= bus.B;
            r_state <= w_divz ? S_DONE : S_PREP;
          end else begin
            r_state <= S_IDLE;
            if (bus.hi_we) r_hi <= bus.wdata;
            if (bus.lo_we) r_lo <= bus.wdata;
          end
        end
        S_PREP: begin
          r_neg_a <= w_signed && r_a[31];
          r_neg_p <= w_signed && (r_a[31] ^ r_b[31]);
          r_mc    <= w_mag_b;
          r_pl    <= w_mag_a;
          r_ph    <= '0;
          r_cnt   <= 6'(ITER - 1);
          r_state <= S_ITER;
        end
        S_ITER: begin
          if (w_div) begin
            r_ph <= w_ge ? w_diff : w_rsh[31:0];
            r_pl <= {r_pl[30:0], w_ge};
          end else begin
            r_ph <= w_msum[32:1];
            r_pl <= {w_msum[0], r_pl[31:1]};
          end
          if (r_cnt == 6'd0) r_state <= S_FIX;
          else               r_cnt   <= r_cnt - 6'd1;
        end
        S_FIX: begin
          if (w_div) begin
            // zero divisor reports the raw dividend, no sign fix-up
            if (w_bz) begin
              r_hi <= r_a;
              r_lo <= '1;
            end else begin
              r_hi <= w_r;
              r_lo <= w_q;
            end
          end else begin
            {r_hi, r_lo} <= w_prod_s;
          end
          r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef MULDIV_DIVZ_EN
  logic r_dz;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_dz <= 1'b0;
    else       r_dz <= w_divz;
  end
  assign bus.dz = r_dz;
`else
  assign bus.dz = 1'b0;
`endif

  assign bus.busy = (r_state == S_PREP) || (r_state == S_ITER) || (r_state == S_FIX);
  assign bus.done = (r_state == S_DONE);
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised and directed checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  muldiv_if u_if ();
  muldiv_unit #(.ITER(32)) dut (.CLK(clk), .nRST(nrst), .bus(u_if.slave));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Result straight from the arithmetic definition of each op.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, b, ph, pl,
                                output logic [31:0] eh, el, output logic edz, output int elat);
    longint sa, sb, p, q, r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    edz = 1'b0;
    elat = 34;
    eh = '0; el = '0;
    case (o)
      2'd0: begin p = sa * sb; {eh, el} = p; end
      2'd1: begin u = {32'b0, a} * {32'b0, b}; {eh, el} = u; end
      default: begin
        if (b == 32'd0) begin
`ifdef MULDIV_DIVZ_EN
          eh = ph; el = pl; edz = 1'b1; elat = 0;
`else
          eh = a; el = 32'hFFFF_FFFF;
`endif
        end else if (o == 2'd2) begin
          q = sa / sb; r = sa % sb;
          eh = r[31:0]; el = q[31:0];
        end else begin
          eh = a % b; el = a / b;
        end
      end
    endcase
  endfunction

  task automatic issue(input logic [1:0] o, input logic [31:0] a, b);
    u_if.start = 1'b1; u_if.op = o; u_if.A = a; u_if.B = b;
    @(posedge clk);
    #1 u_if.start = 1'b0;
  endtask

  // Counts busy cycles until done; also notes whether hi/lo stayed put while busy.
  task automatic wait_done(input logic [31:0] h0, l0, output int cyc, output logic got, output logic held);
    cyc = 0; got = 1'b0; held = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (u_if.done) begin got = 1'b1; break; end
      if (u_if.busy) begin
        cyc++;
        if (u_if.hi !== h0 || u_if.lo !== l0) held = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({u_if.busy, u_if.done, u_if.dz, u_if.hi, u_if.lo} !== 67'd0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b dz=%b hi=%h lo=%h, required all zero",
               u_if.busy, u_if.done, u_if.dz, u_if.hi, u_if.lo);
    end
    @(negedge clk) nrst = 1'b1;
  endtask

  task automatic test_directed();
    logic [1:0]  top [6] = '{2'd1, 2'd0, 2'd2, 2'd2, 2'd3, 2'd0};
    logic [31:0] ta  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h8000_0000, 32'd100, 32'h8000_0000};
    logic [31:0] tb  [6] = '{32'd2, 32'd7, 32'd2, 32'hFFFF_FFFF, 32'd7, 32'h8000_0000};
    logic [31:0] th  [6] = '{32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'd2, 32'h4000_0000};
    logic [31:0] tl  [6] = '{32'hFFFF_FFFE, 32'hFFFF_FFEB, 32'hFFFF_FFFD, 32'h8000_0000, 32'd14, 32'h0};
    logic [31:0] h0, l0;
    int cyc; logic got, held;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      h0 = u_if.hi; l0 = u_if.lo;
      issue(top[i], ta[i], tb[i]);
      wait_done(h0, l0, cyc, got, held);
      n_chk++;
      if (got !== 1'b1 || held !== 1'b1 || cyc != 34) begin
        n_fail++;
        $display("FAIL directed[%0d] timing: got=%b held=%b busy_cycles=%0d, required 1 1 34", i, got, held, cyc);
      end
      n_chk++;
      if ({u_if.hi, u_if.lo, u_if.dz} !== {th[i], tl[i], 1'b0}) begin
        n_fail++;
        $display("FAIL directed[%0d] result: hi=%h lo=%h dz=%b, required %h %h 0",
                 i, u_if.hi, u_if.lo, u_if.dz, th[i], tl[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, h0, l0, eh, el;
    logic [1:0] o;
    logic edz, got, held;
    int cyc, elat, r;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 7);
      a = (r == 0) ? 32'h8000_0000 : (r == 1) ? 32'hFFFF_FFFF : $urandom;
      r = $urandom_range(0, 7);
      b = (r == 0) ? 32'h8000_0000 : (r == 1) ? 32'hFFFF_FFFF : (r == 2) ? 32'd0
        : (r == 3) ? 32'($urandom_range(1, 15)) : $urandom;
      @(negedge clk);
      h0 = u_if.hi; l0 = u_if.lo;
      model(o, a, b, h0, l0, eh, el, edz, elat);
      issue(o, a, b);
      wait_done(h0, l0, cyc, got, held);
      n_chk++;
      if (got !== 1'b1 || held !== 1'b1 || cyc != elat) begin
        n_fail++;
        $display("FAIL random[%0d] timing op=%0d a=%h b=%h: got=%b held=%b busy_cycles=%0d, required 1 1 %0d",
                 i, o, a, b, got, held, cyc, elat);
      end
      n_chk++;
      if ({u_if.hi, u_if.lo, u_if.dz} !== {eh, el, edz}) begin
        n_fail++;
        $display("FAIL random[%0d] result op=%0d a=%h b=%h: hi=%h lo=%h dz=%b, required %h %h %b",
                 i, o, a, b, u_if.hi, u_if.lo, u_if.dz, eh, el, edz);
      end
    end
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] h0, l0;
    int cyc; logic got, held;
    @(negedge clk) begin u_if.hi_we = 1'b1; u_if.wdata = 32'hA5A5_0001; end
    @(posedge clk) #1 u_if.hi_we = 1'b0;
    @(negedge clk) begin u_if.lo_we = 1'b1; u_if.wdata = 32'h5A5A_0002; end
    @(posedge clk) #1 u_if.lo_we = 1'b0;
    n_chk++;
    if ({u_if.hi, u_if.lo} !== {32'hA5A5_0001, 32'h5A5A_0002}) begin
      n_fail++;
      $display("FAIL mthi_mtlo single: hi=%h lo=%h, required a5a50001 5a5a0002", u_if.hi, u_if.lo);
    end
    @(negedge clk) begin u_if.hi_we = 1'b1; u_if.lo_we = 1'b1; u_if.wdata = 32'h0F0F_0F0F; end
    @(posedge clk) #1 begin u_if.hi_we = 1'b0; u_if.lo_we = 1'b0; end
    n_chk++;
    if ({u_if.hi, u_if.lo} !== {2{32'h0F0F_0F0F}}) begin
      n_fail++;
      $display("FAIL mthi_mtlo both: hi=%h lo=%h, required 0f0f0f0f 0f0f0f0f", u_if.hi, u_if.lo);
    end
    // start and a write at the same edge: the write must be lost
    @(negedge clk);
    h0 = u_if.hi; l0 = u_if.lo;
    u_if.hi_we = 1'b1; u_if.lo_we = 1'b1; u_if.wdata = 32'hDEAD_BEEF;
    issue(2'd1, 32'd3, 32'd4);
    u_if.hi_we = 1'b0; u_if.lo_we = 1'b0;
    n_chk++;
    if ({u_if.hi, u_if.lo} !== {h0, l0}) begin
      n_fail++;
      $display("FAIL start_beats_write edge: hi=%h lo=%h, required %h %h", u_if.hi, u_if.lo, h0, l0);
    end
    wait_done(h0, l0, cyc, got, held);
    n_chk++;
    if ({got, held, u_if.hi, u_if.lo} !== {1'b1, 1'b1, 32'd0, 32'd12}) begin
      n_fail++;
      $display("FAIL start_beats_write result: got=%b held=%b hi=%h lo=%h, required 1 1 0 c",
               got, held, u_if.hi, u_if.lo);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] h0, l0, eh, el;
    logic edz, got, held;
    int cyc, elat, pre;
    @(negedge clk);
    h0 = u_if.hi; l0 = u_if.lo;
    issue(2'd1, 32'd3, 32'd5);
    wait_done(h0, l0, cyc, got, held);
    n_chk++;
    if ({got, u_if.lo} !== {1'b1, 32'd15}) begin
      n_fail++;
      $display("FAIL b2b first: got=%b lo=%h, required 1 f", got, u_if.lo);
    end
    // issue in the done cycle itself
    h0 = u_if.hi; l0 = u_if.lo;
    issue(2'd3, 32'd1000, 32'd9);
    wait_done(h0, l0, cyc, got, held);
    n_chk++;
    if ({got, held, u_if.hi, u_if.lo} !== {1'b1, 1'b1, 32'd1, 32'd111} || cyc != 34) begin
      n_fail++;
      $display("FAIL b2b second: got=%b held=%b cycles=%0d hi=%h lo=%h, required 1 1 34 1 6f",
               got, held, cyc, u_if.hi, u_if.lo);
    end
    // start and lo_we while busy must both be ignored
    @(negedge clk);
    h0 = u_if.hi; l0 = u_if.lo;
    model(2'd0, 32'd12345, 32'hFFFF_FFFE, h0, l0, eh, el, edz, elat);
    issue(2'd0, 32'd12345, 32'hFFFF_FFFE);
    pre = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (u_if.busy) pre++;
    end
    u_if.start = 1'b1; u_if.op = 2'd3; u_if.A = 32'd7; u_if.B = 32'd1;
    u_if.lo_we = 1'b1; u_if.wdata = 32'hDEAD_BEEF;
    @(posedge clk) #1 begin u_if.start = 1'b0; u_if.lo_we = 1'b0; end
    wait_done(h0, l0, cyc, got, held);
    n_chk++;
    if ({got, held} !== 2'b11 || pre + cyc != elat) begin
      n_fail++;
      $display("FAIL busy_start timing: got=%b held=%b busy_cycles=%0d, required 1 1 %0d", got, held, pre + cyc, elat);
    end
    n_chk++;
    if ({u_if.hi, u_if.lo} !== {eh, el}) begin
      n_fail++;
      $display("FAIL busy_start result: hi=%h lo=%h, required %h %h", u_if.hi, u_if.lo, eh, el);
    end
    @(negedge clk);
    n_chk++;
    if ({u_if.busy, u_if.done} !== 2'b00) begin
      n_fail++;
      $display("FAIL busy_start not_queued: busy=%b done=%b, required 0 0", u_if.busy, u_if.done);
    end
  endtask

  task automatic test_divzero();
    logic [31:0] ta [2] = '{32'd5, 32'hFFFF_FFFB};
    logic [1:0]  top [2] = '{2'd3, 2'd2};
    logic [31:0] h0, l0, eh, el;
    logic edz, got, held;
    int cyc, elat;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      h0 = u_if.hi; l0 = u_if.lo;
`ifdef MULDIV_DIVZ_EN
      eh = h0; el = l0; edz = 1'b1; elat = 0;
`else
      eh = ta[i]; el = 32'hFFFF_FFFF; edz = 1'b0; elat = 34;
`endif
      issue(top[i], ta[i], 32'd0);
      wait_done(h0, l0, cyc, got, held);
      n_chk++;
      if ({got, held} !== 2'b11 || cyc != elat) begin
        n_fail++;
        $display("FAIL divzero[%0d] timing: got=%b held=%b busy_cycles=%0d, required 1 1 %0d", i, got, held, cyc, elat);
      end
      n_chk++;
      if ({u_if.hi, u_if.lo, u_if.dz} !== {eh, el, edz}) begin
        n_fail++;
        $display("FAIL divzero[%0d] result: hi=%h lo=%h dz=%b, required %h %h %b", i, u_if.hi, u_if.lo, u_if.dz, eh, el, edz);
      end
      @(negedge clk);
      n_chk++;
      if ({u_if.done, u_if.dz} !== 2'b00) begin
        n_fail++;
        $display("FAIL divzero[%0d] pulse: done=%b dz=%b one cycle later, required 0 0", i, u_if.done, u_if.dz);
      end
    end
  endtask

  task automatic test_reset_mid();
    int ndone;
    @(negedge clk) begin u_if.hi_we = 1'b1; u_if.lo_we = 1'b1; u_if.wdata = 32'h66; end
    @(posedge clk) #1 begin u_if.hi_we = 1'b0; u_if.lo_we = 1'b0; end
    @(negedge clk);
    issue(2'd0, 32'd7, 32'd9);
    repeat (12) @(negedge clk);
    nrst = 1'b0;
    #1;
    n_chk++;
    if ({u_if.busy, u_if.done, u_if.hi, u_if.lo} !== 66'd0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h, required all zero", u_if.busy, u_if.done, u_if.hi, u_if.lo);
    end
    @(negedge clk) nrst = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (u_if.done || u_if.busy) ndone++;
    end
    n_chk++;
    if (ndone != 0) begin
      n_fail++;
      $display("FAIL reset_mid no_done: %0d cycles with busy/done after reset, required 0", ndone);
    end
    u_if.lo_we = 1'b1; u_if.wdata = 32'h1234;
    @(posedge clk) #1 u_if.lo_we = 1'b0;
    n_chk++;
    if ({u_if.hi, u_if.lo} !== {32'd0, 32'h1234}) begin
      n_fail++;
      $display("FAIL reset_mid mtlo: hi=%h lo=%h, required 0 1234", u_if.hi, u_if.lo);
    end
  endtask

  initial begin
    u_if.start = 1'b0; u_if.op = 2'd0; u_if.A = '0; u_if.B = '0;
    u_if.hi_we = 1'b0; u_if.lo_we = 1'b0; u_if.wdata = '0;
    test_reset();
    test_directed();
    test_mthi_mtlo();
    test_back_to_back();
    test_divzero();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
